// File: rtl/branch_predictor.sv
// branch_predictor: fetch-stage bimodal predictor (2-bit saturating counters)
// with a direct-mapped branch target buffer sharing the same index.
// Lookup is combinational on PC_F; training happens on the rising edge from
// resolved Execute-stage branches.
// Optional build macro BP_STATS_EN adds saturating branch/mispredict counters.

module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] PC_F,
  output logic        Predict_Taken_F,
  output logic [31:0] Predict_Target_F,
  input  logic [1:0]  Branch_Type_E,
  input  logic [31:0] PC_E,
  input  logic        Branch_Taken_E,
  input  logic [31:0] Branch_Target_E,
  input  logic        Predict_Taken_E
`ifdef BP_STATS_EN
  ,
  output logic [31:0] Branch_Count,
  output logic [31:0] Mispredict_Count
`endif
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_LSB = IDX_BITS + 2;
  localparam int TAG_MSB = IDX_BITS + TAG_BITS + 1;

  localparam logic [1:0] BT_NONE = 2'b00;
  localparam logic [1:0] BT_COND = 2'b01;
  localparam logic [1:0] BT_JAL  = 2'b10;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Table storage
  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  // Address decode for both ports
  logic [IDX_BITS-1:0] idx_f_s;
  logic [IDX_BITS-1:0] idx_e_s;
  logic [TAG_BITS-1:0] tag_f_s;
  logic [TAG_BITS-1:0] tag_e_s;
  logic                hit_f_s;
  logic                hit_e_s;

  // Write-port next-state for the entry addressed by PC_E
  logic                wr_en_s;
  logic [1:0]          wr_ctr_d;
  logic [31:0]         wr_target_d;

  assign idx_f_s = PC_F[IDX_BITS+1:2];
  assign idx_e_s = PC_E[IDX_BITS+1:2];
  assign tag_f_s = PC_F[TAG_MSB:TAG_LSB];
  assign tag_e_s = PC_E[TAG_MSB:TAG_LSB];

  assign hit_f_s = valid_q[idx_f_s] && (tag_q[idx_f_s] == tag_f_s);
  assign hit_e_s = valid_q[idx_e_s] && (tag_q[idx_e_s] == tag_e_s);

  // Fetch lookup: valid gates both outputs, so unwritten entries never leak
  always_comb begin
    Predict_Taken_F  = 1'b0;
    Predict_Target_F = 32'h0000_0000;
    if (hit_f_s) begin
      Predict_Taken_F  = ctr_q[idx_f_s][1];
      Predict_Target_F = target_q[idx_f_s];
    end else begin
      Predict_Taken_F  = 1'b0;
      Predict_Target_F = 32'h0000_0000;
    end
  end

  // Training decision: what, if anything, is written to the Execute entry
  always_comb begin
    wr_en_s     = 1'b0;
    wr_ctr_d    = ctr_q[idx_e_s];
    wr_target_d = target_q[idx_e_s];
    case (Branch_Type_E)
      BT_COND: begin
        if (hit_e_s) begin
          wr_en_s = 1'b1;
          if (Branch_Taken_E) begin
            wr_target_d = Branch_Target_E;
            if (ctr_q[idx_e_s] != CTR_ST) begin
              wr_ctr_d = ctr_q[idx_e_s] + 2'b01;
            end else begin
              wr_ctr_d = CTR_ST;
            end
          end else begin
            if (ctr_q[idx_e_s] != CTR_SNT) begin
              wr_ctr_d = ctr_q[idx_e_s] - 2'b01;
            end else begin
              wr_ctr_d = CTR_SNT;
            end
          end
        end else if (Branch_Taken_E) begin
          // Miss on a taken branch: allocate, evicting any alias
          wr_en_s     = 1'b1;
          wr_ctr_d    = CTR_WT;
          wr_target_d = Branch_Target_E;
        end else begin
          // Miss on a not-taken branch leaves the aliasing entry alone
          wr_en_s = 1'b0;
        end
      end
      BT_JAL: begin
        // JAL is always taken: hit or miss, the entry ends up strongly taken
        wr_en_s     = 1'b1;
        wr_ctr_d    = CTR_ST;
        wr_target_d = Branch_Target_E;
      end
      BT_NONE: begin
        wr_en_s = 1'b0;
      end
      default: begin
        // JALR targets are data dependent; never trained
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Table state: async clear, single-entry write per cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'h0000_0000;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (wr_en_s) begin
      valid_q[idx_e_s]  <= 1'b1;
      tag_q[idx_e_s]    <= tag_e_s;
      target_q[idx_e_s] <= wr_target_d;
      ctr_q[idx_e_s]    <= wr_ctr_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] mispredict_cnt_q;

  // Saturating statistics over every real branch/jump in Execute
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      branch_cnt_q     <= 32'h0000_0000;
      mispredict_cnt_q <= 32'h0000_0000;
    end else if (Branch_Type_E != BT_NONE) begin
      if (branch_cnt_q != 32'hFFFF_FFFF) begin
        branch_cnt_q <= branch_cnt_q + 32'd1;
      end
      if ((Predict_Taken_E != Branch_Taken_E) && (mispredict_cnt_q != 32'hFFFF_FFFF)) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
    end
  end

  assign Branch_Count     = branch_cnt_q;
  assign Mispredict_Count = mispredict_cnt_q;

  logic unused_s;
  assign unused_s = ^{PC_F[31:TAG_MSB+1], PC_F[1:0], PC_E[31:TAG_MSB+1], PC_E[1:0]};
`else
  logic unused_s;
  assign unused_s = ^{PC_F[31:TAG_MSB+1], PC_F[1:0], PC_E[31:TAG_MSB+1], PC_E[1:0],
                      Predict_Taken_E};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a table-level reference model is
// compared against the DUT on every falling edge, and directed scenarios pin
// hand-computed values.

module tb_branch_predictor;

  logic        CLK;
  logic        RST_N;
  logic [31:0] PC_F;
  logic        Predict_Taken_F;
  logic [31:0] Predict_Target_F;
  logic [1:0]  Branch_Type_E;
  logic [31:0] PC_E;
  logic        Branch_Taken_E;
  logic [31:0] Branch_Target_E;
  logic        Predict_Taken_E;
`ifdef BP_STATS_EN
  logic [31:0] Branch_Count;
  logic [31:0] Mispredict_Count;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference model: one record per index, counters as plain integers 0..3
  bit          m_valid [64];
  int          m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_ctr   [64];
  longint      m_bcnt;
  longint      m_mcnt;

  branch_predictor dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .PC_F             (PC_F),
    .Predict_Taken_F  (Predict_Taken_F),
    .Predict_Target_F (Predict_Target_F),
    .Branch_Type_E    (Branch_Type_E),
    .PC_E             (PC_E),
    .Branch_Taken_E   (Branch_Taken_E),
    .Branch_Target_E  (Branch_Target_E),
    .Predict_Taken_E  (Predict_Taken_E)
`ifdef BP_STATS_EN
    ,
    .Branch_Count     (Branch_Count),
    .Mispredict_Count (Mispredict_Count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic int m_tagof(input logic [31:0] pc);
    return int'((pc >> 8) % 256);
  endfunction

  task automatic m_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tgt);
    int i;
    bit hit;
    i   = m_idx(pc);
    hit = m_valid[i] && (m_tag[i] == m_tagof(pc));
    tk  = hit && (m_ctr[i] >= 2);
    tgt = hit ? m_tgt[i] : 32'h0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = 32'h0;
      m_ctr[i]   = 1;
    end
    m_bcnt = 0;
    m_mcnt = 0;
  endtask

  // Apply the Execute-stage outcome currently on the inputs to the model
  task automatic m_update();
    int i;
    bit hit;
    i   = m_idx(PC_E);
    hit = m_valid[i] && (m_tag[i] == m_tagof(PC_E));
    if (Branch_Type_E != 2'b00) begin
      if (m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
      if (Predict_Taken_E != Branch_Taken_E && m_mcnt < 64'hFFFF_FFFF) m_mcnt++;
    end
    if (Branch_Type_E == 2'b01) begin
      if (hit) begin
        if (Branch_Taken_E) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = Branch_Target_E;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (Branch_Taken_E) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = m_tagof(PC_E);
        m_tgt[i]   = Branch_Target_E;
        m_ctr[i]   = 2;
      end
    end else if (Branch_Type_E == 2'b10) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = m_tagof(PC_E);
      m_tgt[i]   = Branch_Target_E;
      m_ctr[i]   = 3;
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge CLK) begin
    logic        etk;
    logic [31:0] etgt;
    if (chk_en && RST_N) begin
      m_lookup(PC_F, etk, etgt);
      check("cyc_taken", {31'b0, Predict_Taken_F}, {31'b0, etk});
      check("cyc_target", Predict_Target_F, etgt);
`ifdef BP_STATS_EN
      check("cyc_bcnt", Branch_Count, m_bcnt[31:0]);
      check("cyc_mcnt", Mispredict_Count, m_mcnt[31:0]);
`endif
    end
  end

  task automatic tick();
    @(posedge CLK);
    m_update();
    #1;
  endtask

  task automatic upd(input logic [1:0] bt, input logic [31:0] pce, input logic tk,
                     input logic [31:0] tgt, input logic pte);
    PC_F            = pce;
    Branch_Type_E   = bt;
    PC_E            = pce;
    Branch_Taken_E  = tk;
    Branch_Target_E = tgt;
    Predict_Taken_E = pte;
    tick();
  endtask

  task automatic look(input logic [31:0] pc, input logic etk, input logic [31:0] etgt,
                      input string name);
    PC_F          = pc;
    Branch_Type_E = 2'b00;
    #1;
    check({name, "_taken"}, {31'b0, Predict_Taken_F}, {31'b0, etk});
    check({name, "_target"}, Predict_Target_F, etgt);
    tick();
  endtask

  initial begin
    RST_N           = 1'b0;
    PC_F            = 32'h100;
    Branch_Type_E   = 2'b00;
    PC_E            = 32'h0;
    Branch_Taken_E  = 1'b0;
    Branch_Target_E = 32'h0;
    Predict_Taken_E = 1'b0;
    m_reset();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("rst_taken_in", {31'b0, Predict_Taken_F}, 32'h0);
    check("rst_target_in", Predict_Target_F, 32'h0);
    RST_N = 1'b1;
    #1;
    chk_en = 1'b1;
    look(32'h100, 1'b0, 32'h0, "rst_lookup");

    // Counter walk on 0x100 (idx 0, tag 1)
    upd(2'b01, 32'h100, 1'b1, 32'h80, 1'b0);
    look(32'h100, 1'b1, 32'h80, "alloc_ctr10");
    upd(2'b01, 32'h100, 1'b0, 32'h0, 1'b0);
    look(32'h100, 1'b0, 32'h80, "ctr01");
    upd(2'b01, 32'h100, 1'b0, 32'h0, 1'b0);
    look(32'h100, 1'b0, 32'h80, "ctr00");
    upd(2'b01, 32'h100, 1'b0, 32'h0, 1'b0);
    look(32'h100, 1'b0, 32'h80, "ctr00_sat");
    upd(2'b01, 32'h100, 1'b1, 32'h80, 1'b0);
    look(32'h100, 1'b0, 32'h80, "up_ctr01");
    upd(2'b01, 32'h100, 1'b1, 32'h80, 1'b0);
    look(32'h100, 1'b1, 32'h80, "up_ctr10");
    upd(2'b01, 32'h100, 1'b1, 32'h80, 1'b0);
    upd(2'b01, 32'h100, 1'b1, 32'h80, 1'b0);
    look(32'h100, 1'b1, 32'h80, "ctr11_sat");
    upd(2'b01, 32'h100, 1'b0, 32'h0, 1'b0);
    look(32'h100, 1'b1, 32'h80, "sat_hi_then_nt");
    upd(2'b01, 32'h100, 1'b0, 32'h0, 1'b0);
    look(32'h100, 1'b0, 32'h80, "down_to_01");
    upd(2'b01, 32'h100, 1'b1, 32'h90, 1'b0);
    look(32'h100, 1'b1, 32'h90, "retarget");

    // Alias at idx 0: 0x000 has tag 0
    look(32'h000, 1'b0, 32'h0, "alias_miss");
    upd(2'b01, 32'h000, 1'b0, 32'h0, 1'b0);
    look(32'h100, 1'b1, 32'h90, "alias_nt_keeps");
    upd(2'b01, 32'h000, 1'b1, 32'h44, 1'b0);
    look(32'h000, 1'b1, 32'h44, "alias_alloc");
    look(32'h100, 1'b0, 32'h0, "alias_evicted");

    // Same-cycle lookup and update of 0x40: no bypass
    PC_F            = 32'h40;
    Branch_Type_E   = 2'b01;
    PC_E            = 32'h40;
    Branch_Taken_E  = 1'b1;
    Branch_Target_E = 32'h400;
    #1;
    check("same_cycle_taken", {31'b0, Predict_Taken_F}, 32'h0);
    tick();
    Branch_Type_E = 2'b00;
    check("next_cycle_taken", {31'b0, Predict_Taken_F}, 32'h1);
    check("next_cycle_target", Predict_Target_F, 32'h400);

    // JAL allocates strongly taken; one NT leaves it predicting taken
    upd(2'b10, 32'h200, 1'b1, 32'h1000, 1'b0);
    look(32'h200, 1'b1, 32'h1000, "jal_alloc");
    upd(2'b01, 32'h200, 1'b0, 32'h0, 1'b0);
    look(32'h200, 1'b1, 32'h1000, "jal_ctr11");

    // JALR and bubbles never allocate
    upd(2'b11, 32'h300, 1'b1, 32'h2000, 1'b0);
    look(32'h300, 1'b0, 32'h0, "jalr_no_alloc");
    upd(2'b00, 32'h500, 1'b1, 32'h3000, 1'b0);
    look(32'h500, 1'b0, 32'h0, "bubble_no_alloc");
    look(32'h200, 1'b1, 32'h1000, "jalr_no_evict");

    // Top index, low PC bits ignored
    upd(2'b01, 32'hFC, 1'b1, 32'h8, 1'b0);
    look(32'hFF, 1'b1, 32'h8, "idx63_lowbits");

    // Asynchronous reset mid-stream, away from any clock edge
    PC_F          = 32'h200;
    Branch_Type_E = 2'b00;
    #1;
    check("pre_rst_taken", {31'b0, Predict_Taken_F}, 32'h1);
    RST_N = 1'b0;
    m_reset();
    #1;
    check("mid_rst_taken", {31'b0, Predict_Taken_F}, 32'h0);
    check("mid_rst_target", Predict_Target_F, 32'h0);
`ifdef BP_STATS_EN
    check("mid_rst_bcnt", Branch_Count, 32'h0);
    check("mid_rst_mcnt", Mispredict_Count, 32'h0);
`endif
    #1;
    RST_N = 1'b1;
    tick();

    // Five updates, two direction mispredicts
    upd(2'b01, 32'h200, 1'b0, 32'h0, 1'b0);
    look(32'h200, 1'b0, 32'h0, "post_rst_miss");
    upd(2'b01, 32'h200, 1'b1, 32'h1200, 1'b0);
    upd(2'b10, 32'h600, 1'b1, 32'h1600, 1'b1);
    upd(2'b11, 32'h700, 1'b1, 32'h1700, 1'b0);
    upd(2'b01, 32'h200, 1'b1, 32'h1200, 1'b1);
    look(32'h200, 1'b1, 32'h1200, "post_rst_train");
`ifdef BP_STATS_EN
    check("stats_bcnt", Branch_Count, 32'd5);
    check("stats_mcnt", Mispredict_Count, 32'd2);
`endif

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor: bimodal table of 2-bit saturating counters plus a direct-mapped branch target buffer (BTB).
- Lookup from PC_F is combinational each cycle. It drives the PC-select mux and the Predict_Taken bit that travels down the pipe to the hazard control unit as Predict_Taken_E.
- Tables are trained synchronously from resolved branch outcomes in Execute.

Parameters:
- IDX_BITS, 6, log2 of entry count (64 entries)
- TAG_BITS, 8, BTB tag width

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RST_N  in  1  asynchronous active-low reset
- PC_F  in  32  fetch PC for lookup
- Predict_Taken_F  out  1  predict redirect to Predict_Target_F
- Predict_Target_F  out  32  predicted target (valid only when Predict_Taken_F=1)
- Branch_Type_E  in  2  00 none/bubble, 01 conditional branch, 10 JAL, 11 JALR
- PC_E  in  32  PC of the Execute instruction
- Branch_Taken_E  in  1  resolved direction
- Branch_Target_E  in  32  resolved target
- Predict_Taken_E  in  1  prediction carried with the E instruction (used by stats only)
- Branch_Count  out  32  stats, present only with BP_STATS_EN
- Mispredict_Count  out  32  stats, present only with BP_STATS_EN

Behaviour:
- Address fields:
  - index = PC[IDX_BITS+1:2]
  - tag = PC[IDX_BITS+TAG_BITS+1:IDX_BITS+2]
  - PC[1:0] are ignored.
- Per entry: valid(1), tag(TAG_BITS), target(32), ctr(2).
  - Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Lookup (combinational, zero latency):
  - hit = valid[idx_F] && tag[idx_F]==tag_F.
  - Predict_Taken_F = hit && ctr[idx_F][1].
  - Predict_Target_F = target[idx_F] when hit, else 32'h0.
- Update (one edge, only when Branch_Type_E is 01 or 10). Let hit_E be the same hit test applied to PC_E.
  - hit_E, conditional:
    - taken: ctr increments, saturating at 11.
    - not taken: ctr decrements, saturating at 00.
    - Target is rewritten with Branch_Target_E when taken.
  - hit_E, JAL: ctr=11, target rewritten.
  - miss_E, taken (conditional or JAL): allocate/overwrite the entry.
    - valid=1, tag=tag_E, target=Branch_Target_E.
    - ctr=10 for conditional, 11 for JAL.
  - miss_E, not taken: no state change; conflicting entries are not evicted.
- JALR (11) and bubbles (00): no table update and never allocated.
  - An aliased lookup on a JALR PC may still predict; Execute corrects it.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents (no bypass). The new state is visible from the next cycle.
- Flush/stall: the predictor has no stall or flush input.
  - Flushed or stalled Execute slots arrive as Branch_Type_E=00, so no update occurs.
  - Lookup is stateless, so a held PC_F re-reads the same prediction.
- Reset (RST_N low, asynchronous): all valid=0, all ctr=01, tags and targets 0.
  - Outputs during reset: Predict_Taken_F=0, Predict_Target_F=0, stats counters 0.
  - Reset asserted mid-operation discards all training. The first update after release is treated as a miss.
- No X propagation from unwritten entries: valid gates every output.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - Branch_Count increments on every update cycle (Branch_Type_E 01/10/11).
  - Mispredict_Count increments on those cycles when Predict_Taken_E != Branch_Taken_E.
  - Both are 32-bit, saturate at 32'hFFFF_FFFF, and reset to 0.
- Undefined: both ports and counters are absent, with no area cost.

Test Plan:
- Reset then lookup PC_F=0x100 -> Predict_Taken_F=0, Predict_Target_F=0.
- Conditional update PC_E=0x100, taken, target 0x80 -> next cycle PC_F=0x100 gives Predict_Taken_F=1, target 0x80 (ctr=10).
- Two not-taken updates to 0x100 -> ctr 10→01→00, Predict_Taken_F=0. Three taken updates -> ctr saturates at 11; a fourth taken update leaves it at 11.
- Alias: entry trained at 0x100 (idx0, tag1), lookup PC_F=0x000 (idx0, tag0) -> Predict_Taken_F=0. A not-taken update at 0x000 leaves the 0x100 entry intact. A taken update at 0x000 overwrites it, and 0x100 then misses.
- Same-cycle update and lookup of 0x40 (first taken update) -> lookup returns 0 that cycle, 1 the next. JAL update at 0x200 -> ctr=11, Predict_Taken_F=1. JALR update at 0x300 -> no allocation.
- BP_STATS_EN: five updates with two Predict_Taken_E/Branch_Taken_E mismatches -> Branch_Count=5, Mispredict_Count=2. Asynchronous RST_N pulse mid-stream clears both counters and all predictions immediately.
